// File: rtl/sfp_ctrl.sv
// Sequencer for one SFP accumulate/ReLU lane: runs tile_num tiles of acc_len
// psum inputs each, strobing clr/acc/relu and holding each tile result for the consumer.
module sfp_ctrl #(
  parameter int psum_bw = 16,
  parameter int cnt_bw  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [cnt_bw-1:0]  acc_len,
  input  logic [cnt_bw-1:0]  tile_num,
  input  logic               relu_en,
  input  logic [psum_bw-1:0] thres_in,
  input  logic               thres_we,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               acc,
  output logic               relu,
  output logic               clr,
  output logic [psum_bw-1:0] thres,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    st_idle = 3'd0,
    st_clr  = 3'd1,
    st_acc  = 3'd2,
    st_relu = 3'd3,
    st_out  = 3'd4
  } state_t;

  state_t               state_r;
  logic [cnt_bw-1:0]    elem_cnt_r;
  logic [cnt_bw-1:0]    tile_cnt_r;
  logic [cnt_bw-1:0]    acc_len_r;
  logic [cnt_bw-1:0]    tile_num_r;
  logic                 relu_en_r;
  logic [psum_bw-1:0]   thres_r;
  logic                 in_ready_r;
  logic                 relu_r;
  logic                 clr_r;
  logic                 out_valid_r;
  logic                 busy_r;
  logic                 done_r;

  logic                 start_ok_s;
  logic                 elem_last_s;
  logic                 tile_last_s;

  // Zero-length jobs are rejected outright so the counters never have to wrap.
  assign start_ok_s  = start && (acc_len != {cnt_bw{1'b0}}) && (tile_num != {cnt_bw{1'b0}});
  assign elem_last_s = (elem_cnt_r == (acc_len_r - cnt_bw'(1)));
  assign tile_last_s = (tile_cnt_r == (tile_num_r - cnt_bw'(1)));

  // Job sequencer; strobes are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= st_idle;
      elem_cnt_r  <= {cnt_bw{1'b0}};
      tile_cnt_r  <= {cnt_bw{1'b0}};
      acc_len_r   <= {cnt_bw{1'b0}};
      tile_num_r  <= {cnt_bw{1'b0}};
      relu_en_r   <= 1'b0;
      in_ready_r  <= 1'b0;
      relu_r      <= 1'b0;
      clr_r       <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      clr_r  <= 1'b0;
      relu_r <= 1'b0;
      done_r <= 1'b0;
      case (state_r)
        st_idle: begin
          if (start_ok_s) begin
            acc_len_r  <= acc_len;
            tile_num_r <= tile_num;
            relu_en_r  <= relu_en;
            tile_cnt_r <= {cnt_bw{1'b0}};
            clr_r      <= 1'b1;
            busy_r     <= 1'b1;
            state_r    <= st_clr;
          end
        end
        st_clr: begin
          elem_cnt_r <= {cnt_bw{1'b0}};
          in_ready_r <= 1'b1;
          state_r    <= st_acc;
        end
        st_acc: begin
          if (in_valid) begin
            elem_cnt_r <= elem_cnt_r + cnt_bw'(1);
            if (elem_last_s) begin
              in_ready_r <= 1'b0;
              if (relu_en_r) begin
                relu_r  <= 1'b1;
                state_r <= st_relu;
              end else begin
                out_valid_r <= 1'b1;
                state_r     <= st_out;
              end
            end
          end
        end
        st_relu: begin
          out_valid_r <= 1'b1;
          state_r     <= st_out;
        end
        st_out: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            if (tile_last_s) begin
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= st_idle;
            end else begin
              tile_cnt_r <= tile_cnt_r + cnt_bw'(1);
              clr_r      <= 1'b1;
              state_r    <= st_clr;
            end
          end
        end
        default: begin
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= st_idle;
        end
      endcase
    end
  end

  // Threshold is writable only between jobs so the lane sees a constant value per job.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      thres_r <= {psum_bw{1'b0}};
    end else if ((state_r == st_idle) && thres_we) begin
      thres_r <= thres_in;
    end
  end

  assign in_ready  = in_ready_r;
  assign acc       = in_valid & in_ready_r;
  assign relu      = relu_r;
  assign clr       = clr_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign thres     = thres_r;

endmodule

// File: tb/tb_sfp_ctrl.sv
// Randomized bench for sfp_ctrl: each job's expected output timeline is derived
// from the latency rules and the stimulus pattern, then compared cycle by cycle.
module tb_sfp_ctrl;

  localparam int maxc = 2048;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  acc_len;
  logic [7:0]  tile_num;
  logic        relu_en;
  logic [15:0] thres_in;
  logic        thres_we;
  logic        in_valid;
  logic        in_ready;
  logic        acc;
  logic        relu;
  logic        clr;
  logic [15:0] thres;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [15:0] thres_m = 16'h0000;

  // expected {in_ready, acc, relu, clr, out_valid, busy, done} per job cycle
  logic [6:0]  exp_o [0:maxc-1];
  bit          iv_a  [0:maxc-1];
  bit          or_a  [0:maxc-1];
  int          len;

  sfp_ctrl #(.psum_bw(16), .cnt_bw(8)) dut (
    .clk(clk), .reset(reset), .start(start), .acc_len(acc_len), .tile_num(tile_num),
    .relu_en(relu_en), .thres_in(thres_in), .thres_we(thres_we), .in_valid(in_valid),
    .in_ready(in_ready), .acc(acc), .relu(relu), .clr(clr), .thres(thres),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {in_ready, acc, relu, clr, out_valid, busy, done};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, expv, $time);
  endtask

  // Timeline: cycle 0 start, then per tile clr, acc window, optional relu, out wait; then done.
  task automatic build(input int al, input int tn, input bit rl);
    int t;
    int k;
    for (int c = 0; c < maxc; c++) exp_o[c] = 7'b0;
    t = 1;
    for (int tile = 0; tile < tn; tile++) begin
      exp_o[t] = 7'b0001010; t++;
      k = 0;
      while (k < al && t < maxc - 8) begin
        exp_o[t][6] = 1'b1; exp_o[t][1] = 1'b1;
        if (iv_a[t]) begin exp_o[t][5] = 1'b1; k++; end
        t++;
      end
      if (rl) begin exp_o[t][4] = 1'b1; exp_o[t][1] = 1'b1; t++; end
      while (t < maxc - 2) begin
        exp_o[t][2] = 1'b1; exp_o[t][1] = 1'b1;
        t++;
        if (or_a[t-1]) break;
      end
    end
    exp_o[t][0] = 1'b1;
    len = t + 1;
  endtask

  // ivmode: 0 always valid, 1 random, 2 alternating from cycle 2. or_from<0 => random ready.
  task automatic run_job(input int al, input int tn, input bit rl, input bit we,
                         input logic [15:0] tv, input int ivmode, input int or_from,
                         input int abort_at);
    for (int c = 0; c < maxc; c++) begin
      case (ivmode)
        0:       iv_a[c] = 1'b1;
        2:       iv_a[c] = (c >= 2) && (((c - 2) % 2) == 0);
        default: iv_a[c] = ($urandom_range(0, 3) != 0);
      endcase
      or_a[c] = (or_from >= 0) ? (c >= or_from) : ($urandom_range(0, 2) == 0);
    end
    build(al, tn, rl);
    for (int c = 0; c < len; c++) begin
      @(posedge clk); #1;
      in_valid  = iv_a[c];
      out_ready = or_a[c];
      if (c == 0) begin
        start = 1'b1; acc_len = al[7:0]; tile_num = tn[7:0]; relu_en = rl;
        thres_we = we; thres_in = tv;
      end else if (c == len - 1) begin
        start = 1'b0; thres_we = 1'b0;
      end else begin
        start    = ($urandom_range(0, 3) == 0);
        acc_len  = 8'($urandom);
        tile_num = 8'($urandom);
        relu_en  = 1'($urandom);
        thres_we = 1'($urandom);
        thres_in = 16'($urandom);
      end
      @(negedge clk);
      check("outs", 32'(outs()), 32'(exp_o[c]));
      check("thres", 32'(thres), 32'(thres_m));
      if (c == 0 && we) thres_m = tv;
      if (c == abort_at) begin
        in_valid = 1'b1;
        reset = 1'b0;
        #1;
        thres_m = 16'h0000;
        check("rst_outs", 32'(outs()), 32'h0);
        check("rst_thres", 32'(thres), 32'(thres_m));
        start = 1'b0; thres_we = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("post_rst", 32'(outs()), 32'h0);
        end
        break;
      end
    end
    start = 1'b0; thres_we = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; acc_len = 8'd0; tile_num = 8'd0; relu_en = 1'b0;
    thres_in = 16'h0000; thres_we = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #12;
    check("reset_outs", 32'(outs()), 32'h0);
    check("reset_thres", 32'(thres), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // idle threshold write
    thres_we = 1'b1; thres_in = 16'h0003;
    @(posedge clk); #1;
    thres_we = 1'b0; thres_m = 16'h0003;
    check("idle_thres", 32'(thres), 32'(thres_m));

    // zero-length starts are ignored
    start = 1'b1; acc_len = 8'd0; tile_num = 8'd3;
    @(posedge clk); #1;
    tile_num = 8'd0; acc_len = 8'd3;
    @(negedge clk);
    check("ign_len0", 32'(outs()), 32'h0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("ign_tile0", 32'(outs()), 32'h0);

    run_job(4, 1, 1'b1, 1'b1, 16'h0005, 0, 9, -1);
    run_job(3, 1, 1'b0, 1'b0, 16'h0000, 2, 10, -1);
    run_job(2, 3, 1'b0, 1'b0, 16'h0000, 0, -1, -1);
    run_job(1, 2, 1'b1, 1'b1, 16'h0009, 1, -1, -1);
    run_job(255, 1, 1'b0, 1'b0, 16'h0000, 1, -1, -1);
    run_job(5, 1, 1'b1, 1'b1, 16'h00a5, 0, -1, 4);

    for (int j = 0; j < 20; j++)
      run_job($urandom_range(1, 8), $urandom_range(1, 4), 1'($urandom), 1'($urandom),
              16'($urandom), 1, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
